pool2d_stream: RTL and testbench
================================

POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 Parameters: DATA_W=23, pixel width; IMG_W=22, input columns; IMG_H=22, input rows; CHANNELS=1, interleaved channels; POOL=2, window and stride, power of two, 2..8.
REQ-002 clk  in  1  single clock; every register updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 en  in  1  run enable; a low level aborts the frame and returns the block to IDLE.
REQ-005 mode  in  1  0=max, 1=average; sampled only at frame start.
REQ-006 in_valid  in  1  input sample valid.
REQ-007 in_data  in  DATA_W  signed input sample.
REQ-008 in_ready  out  1  block accepts in_data this cycle.
REQ-009 out_valid  out  1  pooled result valid.
REQ-010 out_data  out  DATA_W  signed pooled result.
REQ-011 out_ready  in  1  downstream accepts out_data.
REQ-012 frame_done  out  1  one-cycle pulse after the last pooled result of a frame is accepted.

Function
REQ-013 Input order SHALL be raster: channel innermost, then column, then row; counters ch_cnt, col_cnt and row_cnt track position.
REQ-014 A transfer SHALL occur when in_valid and in_ready are both high; in_ready SHALL equal (state==RUN) && (!out_valid || out_ready).
REQ-015 The partial-result line buffer SHALL hold (IMG_W/POOL)*CHANNELS entries; no full-frame storage.
REQ-016 First element of a window (row%POOL==0, col%POOL==0): entry loaded with the sample; any other element: entry combined with the sample.
REQ-017 Max combine SHALL use signed comparison; average combine SHALL sum into DATA_W+2*log2(POOL) bits.
REQ-018 Average result SHALL be the sum arithmetically shifted right by 2*log2(POOL), truncated toward negative infinity, taken as DATA_W bits.
REQ-019 Last element of a window (both indices %POOL==POOL-1): out_data/out_valid SHALL be registered on the same edge that accepts the sample (latency 1 cycle).
REQ-020 out_valid SHALL hold, with out_data stable, until out_ready is high.
REQ-021 Trailing rows/columns with index >= (IMG_W/POOL)*POOL or >= (IMG_H/POOL)*POOL SHALL be accepted and discarded.
REQ-022 FSM states: IDLE, RUN, LAST.
REQ-023 IDLE->RUN when en=1; mode is latched on this transition.
REQ-024 RUN->LAST when the final sample of the frame is accepted.
REQ-025 LAST->RUN when the final result is accepted; frame_done pulses on that transition, counters clear and mode is relatched.
REQ-026 en=0 in any state: next cycle go to IDLE, drop out_valid, clear counters; line buffer contents are don't-care.
REQ-027 Simultaneous out_ready accept and new final-element input SHALL load the new result with no bubble.

Reset
REQ-028 On rst_n=0: state=IDLE, all counters 0, out_valid=0, out_data=0, frame_done=0, in_ready=0; line buffer is not cleared.
REQ-029 Reset mid-frame SHALL discard the partial frame; after release, the next frame starts at row 0, col 0, ch 0.

Configuration
REQ-030 Macro POOL2D_AVG_MODE_EN: when defined, average mode and wide accumulators are built in; when undefined, mode is ignored, max only, accumulator width is DATA_W.

Structure
REQ-031 Package cnn_pkg holds the pool_mode_e enum (POOL_MAX, POOL_AVG), the pool2d_state_e enum and default DATA_W.
REQ-032 Sub-module pool_combine (combinational: load/max/add and the final shift) is instantiated once.

Verification
REQ-033 4x4 image, POOL=2, max, values 0..15 raster -> outputs 5,7,13,15, then a frame_done pulse.
REQ-034 Same frame in avg mode -> outputs 2,4,10,12 (floor); all -1 input -> -1.
REQ-035 Signed max: window {-5,-3,-8,-1} -> -1; window {-7,3,-2,0} -> 3.
REQ-036 CHANNELS=2, 4x4, ch1 = -ch0 -> interleaved outputs 5,-0,7,-2,... with ch order preserved.
REQ-037 out_ready held low for 10 cycles mid-frame -> in_ready low, out_data stable, no sample lost.
REQ-038 5x5 image -> 4 outputs only (row/col 4 discarded); en dropped at sample 7 -> IDLE; next frame matches REQ-033.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types for the CNN streaming blocks.
// Pool mode, pool FSM state and the default pixel width.
package cnn_pkg;

  localparam int DEF_DATA_W = 23;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } pool2d_state_e;

endpackage

// File: rtl/pool_combine.sv
// Window combine: load, signed max or add, then the average shift.
// Average path is built only with POOL2D_AVG_MODE_EN defined.
module pool_combine
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_DATA_W,
  parameter int SHIFT  = 2
) (
  input  logic              first,
  input  pool_mode_e        mode,
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] sample,
  output logic [ACC_W-1:0]  acc_next,
  output logic [DATA_W-1:0] result
);

  logic signed [ACC_W-1:0] s_ext;
  logic                    take;

  assign s_ext = ACC_W'($signed(sample));
  assign take  = first || (s_ext > $signed(acc));

`ifdef POOL2D_AVG_MODE_EN
  always_comb begin
    acc_next = take ? s_ext : acc;
    result   = acc_next[DATA_W-1:0];
    if (mode == POOL_AVG) begin
      acc_next = first ? s_ext : acc + s_ext;
      result   = DATA_W'($signed(acc_next) >>> SHIFT);
    end
  end
`else
  logic mode_unused;
  assign mode_unused = (mode == POOL_AVG);
  assign acc_next    = take ? s_ext : acc;
  assign result      = acc_next[DATA_W-1:0];
`endif

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2D max/average pooling over a raster pixel stream.
// Average mode requires POOL2D_AVG_MODE_EN; otherwise max only.
module pool2d_stream
  import cnn_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IMG_W    = 22,
  parameter int IMG_H    = 22,
  parameter int CHANNELS = 1,
  parameter int POOL     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              frame_done
);

  localparam int LOG2P = $clog2(POOL);
`ifdef POOL2D_AVG_MODE_EN
  localparam int ACC_W = DATA_W + 2 * LOG2P;
`else
  localparam int ACC_W = DATA_W;
`endif
  localparam int OUT_W = IMG_W / POOL;
  localparam int USE_W = OUT_W * POOL;
  localparam int USE_H = (IMG_H / POOL) * POOL;
  localparam int LB_N  = OUT_W * CHANNELS;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam int IDX_W = (LB_N > 1) ? $clog2(LB_N) : 1;

  pool2d_state_e state;
  pool_mode_e    mode_q;

  logic [CH_W-1:0]  ch_cnt;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;

  logic [ACC_W-1:0] lbuf [LB_N];

  logic              fire;
  logic              first;
  logic              win_last;
  logic              in_use;
  logic              last_sample;
  logic [IDX_W-1:0]  lb_idx;
  logic [ACC_W-1:0]  acc_rd;
  logic [ACC_W-1:0]  acc_nx;
  logic [DATA_W-1:0] result;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  assign first    = (col_cnt[LOG2P-1:0] == '0)
                 && (row_cnt[LOG2P-1:0] == '0);
  assign win_last = (&col_cnt[LOG2P-1:0])
                 && (&row_cnt[LOG2P-1:0]);
  assign in_use   = (col_cnt < COL_W'(USE_W))
                 && (row_cnt < ROW_W'(USE_H));

  assign last_sample = (ch_cnt == CH_W'(CHANNELS - 1))
                    && (col_cnt == COL_W'(IMG_W - 1))
                    && (row_cnt == ROW_W'(IMG_H - 1));

  assign lb_idx = IDX_W'(((int'(col_cnt) >> LOG2P) * CHANNELS)
                  + int'(ch_cnt));
  assign acc_rd = lbuf[lb_idx];

  pool_combine #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SHIFT  (2 * LOG2P)
  ) u_combine (
    .first    (first),
    .mode     (mode_q),
    .acc      (acc_rd),
    .sample   (in_data),
    .acc_next (acc_nx),
    .result   (result)
  );

  // Partial sums only; never reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (rst_n && en && fire && in_use)
      lbuf[lb_idx] <= acc_nx;
  end

  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= POOL_MAX;
      ch_cnt    <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!en) begin
      state     <= IDLE;
      ch_cnt    <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          state  <= RUN;
          mode_q <= pool_mode_e'(mode);
        end
        RUN: begin
          if (fire) begin
            if (in_use && win_last) begin
              out_valid <= 1'b1;
              out_data  <= result;
            end
            if (ch_cnt == CH_W'(CHANNELS - 1)) begin
              ch_cnt <= '0;
              if (col_cnt == COL_W'(IMG_W - 1)) begin
                col_cnt <= '0;
                if (row_cnt == ROW_W'(IMG_H - 1))
                  row_cnt <= '0;
                else
                  row_cnt <= row_cnt + ROW_W'(1);
              end else begin
                col_cnt <= col_cnt + COL_W'(1);
              end
            end else begin
              ch_cnt <= ch_cnt + CH_W'(1);
            end
            if (last_sample)
              state <= LAST;
          end
        end
        LAST: begin
          if (!out_valid || out_ready) begin
            state      <= RUN;
            frame_done <= 1'b1;
            mode_q     <= pool_mode_e'(mode);
            ch_cnt     <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: three instances (4x4, 4x4x2ch, 5x5).
// Average expectations follow POOL2D_AVG_MODE_EN.
module tb_pool2d_stream;

  localparam int DW = 23;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [2:0]    en = 3'b000;
  logic [2:0]    rdy;
  logic [2:0]    ov;
  logic [2:0]    fd;
  logic [DW-1:0] od0, od1, od2;

  int vectors = 0;
  int errs = 0;
  int q0[$], q1[$], q2[$];
  int vals[$];
  int want[$];
  int fdc0 = 0, fdc1 = 0, fdc2 = 0;
  int bp_w, bp_stable, bp_blocked;
  logic [DW-1:0] bp_held;

  always #5 clk = ~clk;

  pool2d_stream #(
    .DATA_W(DW), .IMG_W(4), .IMG_H(4), .CHANNELS(1), .POOL(2)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .out_valid(ov[0]), .out_data(od0), .out_ready(out_ready),
    .frame_done(fd[0])
  );

  pool2d_stream #(
    .DATA_W(DW), .IMG_W(4), .IMG_H(4), .CHANNELS(2), .POOL(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
    .out_valid(ov[1]), .out_data(od1), .out_ready(out_ready),
    .frame_done(fd[1])
  );

  pool2d_stream #(
    .DATA_W(DW), .IMG_W(5), .IMG_H(5), .CHANNELS(1), .POOL(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[2]),
    .out_valid(ov[2]), .out_data(od2), .out_ready(out_ready),
    .frame_done(fd[2])
  );

  always @(negedge clk) begin
    if (ov[0] && out_ready) q0.push_back(int'($signed(od0)));
    if (ov[1] && out_ready) q1.push_back(int'($signed(od1)));
    if (ov[2] && out_ready) q2.push_back(int'($signed(od2)));
    if (fd[0]) fdc0++;
    if (fd[1]) fdc1++;
    if (fd[2]) fdc2++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int got[$],
                             input int exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    foreach (exp[i])
      check($sformatf("%s_out%0d", tag, i),
            (i < got.size()) ? got[i] : -999999, exp[i]);
  endtask

  task automatic ramp(input int n);
    vals.delete();
    for (int i = 0; i < n; i++) vals.push_back(i);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed(input int sel, input int v[$]);
    foreach (v[i]) begin
      int w;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = DW'(v[i]);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!rdy[sel] && w < 200);
      if (!rdy[sel]) begin
        check("feed_timeout", int'(rdy[sel]), 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    step(3);
    check("rst_out_valid", int'(ov[0]), 0);
    check("rst_in_ready", int'(rdy[0]), 0);
    check("rst_frame_done", int'(fd[0]), 0);
    check("rst_out_data", int'(od0), 0);
    rst_n = 1'b1;
    step(1);

    // max, 0..15 raster
    mode = 1'b0;
    en[0] = 1'b1;
    q0.delete();
    ramp(16);
    feed(0, vals);
    step(6);
    want = {5, 7, 13, 15};
    check_frame("max4", q0, want);
    check("max4_done", fdc0, 1);

    // average, mode relatched through IDLE
    en[0] = 1'b0;
    step(2);
    mode = 1'b1;
    en[0] = 1'b1;
    q0.delete();
    feed(0, vals);
    step(6);
`ifdef POOL2D_AVG_MODE_EN
    want = {2, 4, 10, 12};
`else
    want = {5, 7, 13, 15};
`endif
    check_frame("avg4", q0, want);
    check("avg4_done", fdc0, 2);

    q0.delete();
    vals.delete();
    for (int i = 0; i < 16; i++) vals.push_back(-1);
    feed(0, vals);
    step(6);
    want = {-1, -1, -1, -1};
    check_frame("avg_neg1", q0, want);

    // signed max
    en[0] = 1'b0;
    step(2);
    mode = 1'b0;
    en[0] = 1'b1;
    q0.delete();
    vals = {-5, -3, -7, 3, -8, -1, -2, 0,
            0, 0, 0, 0, 0, 0, 0, 0};
    feed(0, vals);
    step(6);
    want = {-1, 3, 0, 0};
    check_frame("smax", q0, want);
    check("smax_done", fdc0, 4);

    // backpressure mid-frame
    q0.delete();
    out_ready = 1'b0;
    ramp(16);
    fork
      feed(0, vals);
      begin
        bp_w = 0;
        bp_stable = 1;
        bp_blocked = 1;
        while (!ov[0] && bp_w < 100) begin
          @(negedge clk);
          bp_w++;
        end
        check("bp_valid", int'(ov[0]), 1);
        bp_held = od0;
        repeat (10) begin
          @(negedge clk);
          if (od0 !== bp_held || !ov[0]) bp_stable = 0;
          if (rdy[0]) bp_blocked = 0;
        end
        check("bp_data_stable", bp_stable, 1);
        check("bp_in_ready_low", bp_blocked, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    step(6);
    want = {5, 7, 13, 15};
    check_frame("bp", q0, want);
    check("bp_done", fdc0, 5);

    // reset mid-frame
    ramp(6);
    feed(0, vals);
    rst_n = 1'b0;
    step(1);
    check("midrst_out_valid", int'(ov[0]), 0);
    rst_n = 1'b1;
    step(1);
    q0.delete();
    ramp(16);
    feed(0, vals);
    step(6);
    want = {5, 7, 13, 15};
    check_frame("midrst", q0, want);
    check("midrst_done", fdc0, 6);
    en[0] = 1'b0;
    step(2);

    // two interleaved channels, ch1 = -ch0
    en[1] = 1'b1;
    q1.delete();
    vals.delete();
    for (int p = 0; p < 16; p++) begin
      vals.push_back(p);
      vals.push_back(-p);
    end
    feed(1, vals);
    step(6);
    want = {5, 0, 7, -2, 13, -8, 15, -10};
    check_frame("ch2", q1, want);
    check("ch2_done", fdc1, 1);
    en[1] = 1'b0;
    step(2);

    // 5x5, trailing row and column discarded
    en[2] = 1'b1;
    q2.delete();
    ramp(25);
    feed(2, vals);
    step(6);
    want = {6, 8, 16, 18};
    check_frame("img5", q2, want);
    check("img5_done", fdc2, 1);

    // abort after 7 samples
    ramp(7);
    feed(2, vals);
    en[2] = 1'b0;
    step(2);
    check("abort_in_ready", int'(rdy[2]), 0);
    check("abort_out_valid", int'(ov[2]), 0);
    en[2] = 1'b1;
    q2.delete();
    ramp(25);
    feed(2, vals);
    step(6);
    want = {6, 8, 16, 18};
    check_frame("after_abort", q2, want);
    check("after_abort_done", fdc2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
